// File: rtl/posit_normalize_accum_pipe_pkg.sv
// Shared posit definitions: default geometry, accumulator value bundle,
// and maxpos/minpos magnitude helpers used by the encoder pipeline.
package posit_normalize_accum_pipe_pkg;

   localparam int unsigned POSIT_NBITS = 32;
   localparam int unsigned POSIT_ES    = 2;
   localparam int unsigned ACC_FBITS   = 147;
   localparam int unsigned ACC_SCALE_W = 8;

   // Accumulator value in default geometry
   typedef struct packed {
      logic                   sgn;
      logic [ACC_SCALE_W-1:0] scale;
      logic [ACC_FBITS-1:0]   fraction;
      logic                   inf;
      logic                   zero;
   } value_accum_t;

   // Largest posit magnitude (all ones below the sign bit)
   function automatic logic [63:0] maxpos_mag(input int unsigned nbits);
      return (64'd1 << (nbits - 1)) - 64'd1;
   endfunction

   // Smallest nonzero posit magnitude
   function automatic logic [63:0] minpos_mag();
      return 64'd1;
   endfunction

endpackage

// File: rtl/posit_normalize_accum_pipe_round_sat.sv
// Final-stage rounding and saturation (combinational).
// Ports: sgn_i/mag_i/guard_i/sticky_i  truncated magnitude plus round bits
//        inf_i/zero_i                  special-case flags
//        result_c/inf_c/zero_c         encoded posit and its flags
module posit_normalize_accum_pipe_round_sat
   import posit_normalize_accum_pipe_pkg::*;
#(
   parameter int unsigned NBITS = POSIT_NBITS
) (
   input  logic             sgn_i,
   input  logic [NBITS-2:0] mag_i,
   input  logic             guard_i,
   input  logic             sticky_i,
   input  logic             inf_i,
   input  logic             zero_i,
   output logic [NBITS-1:0] result_c,
   output logic             inf_c,
   output logic             zero_c
);

   logic             inc;
   logic [NBITS-1:0] rounded;
   logic [NBITS-2:0] sat;
   logic [NBITS-2:0] signed_mag;

   // Nearest-even round, clamp into [minpos, maxpos], apply sign, then specials
   always_comb begin
      result_c   = '0;
      inf_c      = 1'b0;
      zero_c     = 1'b0;
      inc        = guard_i & (mag_i[0] | sticky_i);
      rounded    = {1'b0, mag_i} + NBITS'(inc);
      if (rounded[NBITS-1]) begin
         sat = (NBITS-1)'(maxpos_mag(NBITS));
      end else if (rounded[NBITS-2:0] == '0) begin
         sat = (NBITS-1)'(minpos_mag());
      end else begin
         sat = rounded[NBITS-2:0];
      end
      signed_mag = sgn_i ? -sat : sat;
      if (inf_i) begin
         result_c[NBITS-1] = 1'b1;
         inf_c             = 1'b1;
      end else if (zero_i) begin
         zero_c = 1'b1;
      end else begin
         result_c = {sgn_i, signed_mag};
      end
   end

endmodule

// File: rtl/posit_normalize_accum_pipe.sv
// Three-stage posit encoder for normalized accumulator values.
// Ports: clk/reset                  clock, async active-high reset
//        in_valid/in_ready          input handshake
//        in_sgn/in_scale/in_fraction/in_inf/in_zero/in_truncated  input value
//        out_valid/out_ready        output handshake (global stall)
//        out_result/out_inf/out_zero  encoded posit and flags
module posit_normalize_accum_pipe
   import posit_normalize_accum_pipe_pkg::*;
#(
   parameter int unsigned NBITS   = POSIT_NBITS,
   parameter int unsigned ES      = POSIT_ES,
   parameter int unsigned FBITS   = ACC_FBITS,
   parameter int unsigned SCALE_W = ACC_SCALE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sgn,
   input  logic [SCALE_W-1:0] in_scale,
   input  logic [FBITS-1:0]   in_fraction,
   input  logic               in_inf,
   input  logic               in_zero,
   input  logic               in_truncated,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NBITS-1:0]   out_result,
   output logic               out_inf,
   output logic               out_zero
);

   // Fraction bits that can ever reach the word or guard; the rest is sticky
   localparam int unsigned FT_W      = NBITS - 2 - ES;
   localparam int unsigned LO_W      = FBITS - FT_W;
   localparam int unsigned SH_W      = $clog2(NBITS);
   localparam int unsigned K_W       = SH_W + 1;
   localparam int unsigned EXT_W     = 2 * NBITS - 2;
   localparam int          SCALE_MAX = int'((NBITS - 2) << ES);
   localparam int          EXP_MASK  = int'((1 << ES) - 1);

   logic stall;

   // S1 state
   logic              s1_valid_q, s1_sgn_q, s1_inf_q, s1_zero_q, s1_neg_q, s1_sticky_q;
   logic [SH_W-1:0]   s1_sh_q;
   logic [NBITS-3:0]  s1_body_q;
   // S2 state
   logic              s2_valid_q, s2_sgn_q, s2_inf_q, s2_zero_q, s2_guard_q, s2_sticky_q;
   logic [NBITS-2:0]  s2_mag_q;
   // Output state
   logic              out_valid_q, out_inf_q, out_zero_q;
   logic [NBITS-1:0]  out_result_q;

   // Next-state values
   logic signed [31:0]    scale_s, scale_c;
   logic signed [K_W-1:0] k_d;
   logic                  s1_neg_d, s1_sticky_d;
   logic [SH_W-1:0]       s1_sh_d;
   logic [NBITS-3:0]      exp_d, s1_body_d;
   logic [EXT_W-1:0]      ext_d, shifted_d;
   logic [NBITS-2:0]      s2_mag_d;
   logic                  s2_guard_d, s2_sticky_d;
   logic [NBITS-1:0]      out_result_d;
   logic                  out_inf_d, out_zero_d;

   assign stall      = out_valid_q & ~out_ready;
   assign in_ready   = ~stall;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_inf    = out_inf_q;
   assign out_zero   = out_zero_q;

   // S1: clamp scale, split into regime run length and exponent, pre-sticky
   always_comb begin
      scale_s = 32'(signed'(in_scale));
      if (scale_s > SCALE_MAX) begin
         scale_c = SCALE_MAX;
      end else if (scale_s < -SCALE_MAX) begin
         scale_c = -SCALE_MAX;
      end else begin
         scale_c = scale_s;
      end
      k_d         = K_W'(scale_c >>> ES);
      s1_neg_d    = k_d[K_W-1];
      // Shift that stretches the "10"/"01" seed into the full regime run
      s1_sh_d     = s1_neg_d ? SH_W'(~k_d) : SH_W'(k_d);
      exp_d       = (NBITS-2)'(scale_c & EXP_MASK);
      s1_body_d   = (exp_d << FT_W) | (NBITS-2)'(in_fraction[FBITS-1 -: FT_W]);
      s1_sticky_d = in_truncated | (|in_fraction[LO_W-1:0]);
   end

   // S2: regime insertion; positive regimes fill with ones, negative with zeros
   always_comb begin
      ext_d       = {(s1_neg_q ? 2'b01 : 2'b10), s1_body_q, (NBITS-2)'(0)};
      shifted_d   = s1_neg_q ? (ext_d >> s1_sh_q) : ~((~ext_d) >> s1_sh_q);
      s2_mag_d    = shifted_d[EXT_W-1 -: NBITS-1];
      s2_guard_d  = shifted_d[NBITS-2];
      s2_sticky_d = s1_sticky_q | (|shifted_d[NBITS-3:0]);
   end

   // S3: round, saturate, negate, special cases
   posit_normalize_accum_pipe_round_sat #(
      .NBITS (NBITS)
   ) u_round_sat (
      .sgn_i    (s2_sgn_q),
      .mag_i    (s2_mag_q),
      .guard_i  (s2_guard_q),
      .sticky_i (s2_sticky_q),
      .inf_i    (s2_inf_q),
      .zero_i   (s2_zero_q),
      .result_c (out_result_d),
      .inf_c    (out_inf_d),
      .zero_c   (out_zero_d)
   );

   // Pipeline registers; everything freezes together on a downstream stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_sgn_q     <= 1'b0;
         s1_inf_q     <= 1'b0;
         s1_zero_q    <= 1'b0;
         s1_neg_q     <= 1'b0;
         s1_sticky_q  <= 1'b0;
         s1_sh_q      <= '0;
         s1_body_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_sgn_q     <= 1'b0;
         s2_inf_q     <= 1'b0;
         s2_zero_q    <= 1'b0;
         s2_guard_q   <= 1'b0;
         s2_sticky_q  <= 1'b0;
         s2_mag_q     <= '0;
         out_valid_q  <= 1'b0;
         out_inf_q    <= 1'b0;
         out_zero_q   <= 1'b0;
         out_result_q <= '0;
      end else if (!stall) begin
         s1_valid_q   <= in_valid;
         s1_sgn_q     <= in_sgn;
         s1_inf_q     <= in_inf;
         s1_zero_q    <= in_zero;
         s1_neg_q     <= s1_neg_d;
         s1_sticky_q  <= s1_sticky_d;
         s1_sh_q      <= s1_sh_d;
         s1_body_q    <= s1_body_d;
         s2_valid_q   <= s1_valid_q;
         s2_sgn_q     <= s1_sgn_q;
         s2_inf_q     <= s1_inf_q;
         s2_zero_q    <= s1_zero_q;
         s2_guard_q   <= s2_guard_d;
         s2_sticky_q  <= s2_sticky_d;
         s2_mag_q     <= s2_mag_d;
         out_valid_q  <= s2_valid_q;
         out_inf_q    <= out_inf_d;
         out_zero_q   <= out_zero_d;
         out_result_q <= out_result_d;
      end
   end

endmodule

// File: tb/tb_posit_normalize_accum_pipe.sv
// Scoreboard bench for posit_normalize_accum_pipe (NBITS=32, ES=2).
module tb_posit_normalize_accum_pipe;

   localparam int unsigned NBITS   = 32;
   localparam int unsigned ES      = 2;
   localparam int unsigned FBITS   = 147;
   localparam int unsigned SCALE_W = 8;

   typedef struct packed {
      logic [NBITS-1:0] res;
      logic             inf;
      logic             zero;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic               in_sgn;
   logic [SCALE_W-1:0] in_scale;
   logic [FBITS-1:0]   in_fraction;
   logic               in_inf;
   logic               in_zero;
   logic               in_truncated;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [NBITS-1:0]   out_result;
   logic               out_inf;
   logic               out_zero;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks      = 0;
   int   errors      = 0;
   int   cyc         = 0;
   int   burst_start = 0;
   int   beat_no     = 0;
   bit   stall_en    = 1'b0;
   logic [31:0] burst_exp [6] = '{32'h40000000, 32'h48000000, 32'h50000000,
                                  32'h58000000, 32'h60000000, 32'h64000000};

   posit_normalize_accum_pipe #(
      .NBITS   (NBITS),
      .ES      (ES),
      .FBITS   (FBITS),
      .SCALE_W (SCALE_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sgn       (in_sgn),
      .in_scale     (in_scale),
      .in_fraction  (in_fraction),
      .in_inf       (in_inf),
      .in_zero      (in_zero),
      .in_truncated (in_truncated),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_inf      (out_inf),
      .out_zero     (out_zero)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [FBITS-1:0] fr(input int a, input int b);
      logic [FBITS-1:0] f;
      f = '0;
      if (a >= 0) f[a] = 1'b1;
      if (b >= 0) f[b] = 1'b1;
      return f;
   endfunction

   // Present one beat, retrying while stalled; expectation queued on acceptance
   task automatic drive(input logic sgn, input logic [SCALE_W-1:0] scale,
                        input logic [FBITS-1:0] frac, input logic inf,
                        input logic zero, input logic trunc,
                        input logic [NBITS-1:0] eres, input logic einf,
                        input logic ezero);
      exp_t e;
      int   tries;
      bit   done;
      tries = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge clk);
         in_valid     = 1'b1;
         in_sgn       = sgn;
         in_scale     = scale;
         in_fraction  = frac;
         in_inf       = inf;
         in_zero      = zero;
         in_truncated = trunc;
         #1;
         if (in_ready) begin
            e.res  = eres;
            e.inf  = einf;
            e.zero = ezero;
            exp_q.push_back(e);
            done = 1'b1;
         end else begin
            tries++;
            if (tries > 100) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout actual=in_ready_low required=accept");
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Downstream back-pressure: out_ready low for burst cycles 4..8
   initial forever begin
      @(negedge clk);
      cyc++;
      out_ready = !(stall_en && (cyc - burst_start) >= 4 && (cyc - burst_start) <= 8);
   end

   // Monitor: compare every presented result against the queue head
   initial forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_beat actual=%h required=no_beat", out_result);
         end else if (out_ready) begin
            mon_e = exp_q.pop_front();
            check($sformatf("beat%0d", beat_no), 64'({out_result, out_inf, out_zero}), 64'(mon_e));
            beat_no++;
         end else begin
            check($sformatf("stall_hold%0d", beat_no), 64'({out_result, out_inf, out_zero}),
                  64'(exp_q[0]));
            check("in_ready_stall", 64'(in_ready), 64'd0);
         end
      end
   end

   initial begin
      int waitc;
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_sgn       = 1'b0;
      in_scale     = '0;
      in_fraction  = '0;
      in_inf       = 1'b0;
      in_zero      = 1'b0;
      in_truncated = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_outputs", 64'({out_result, out_inf, out_zero}), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("release_in_ready", 64'(in_ready), 64'd1);

      // Directed encodings
      drive(1'b0, 8'd0,   '0,          1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0);
      drive(1'b1, 8'd0,   '0,          1'b0, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0);
      drive(1'b0, 8'd1,   '0,          1'b0, 1'b0, 1'b0, 32'h48000000, 1'b0, 1'b0);
      drive(1'b0, 8'd127, fr(5, -1),   1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
      drive(1'b0, 8'h80,  fr(3, -1),   1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
      drive(1'b0, 8'd0,   '0,          1'b1, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0);
      drive(1'b0, 8'd0,   '0,          1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1);
      drive(1'b1, 8'd9,   fr(146, -1), 1'b1, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0);
      drive(1'b1, 8'd9,   fr(146, -1), 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1);
      drive(1'b0, 8'd0,   fr(146, -1), 1'b0, 1'b0, 1'b0, 32'h44000000, 1'b0, 1'b0);
      drive(1'b0, 8'd0,   fr(119, -1), 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0);
      drive(1'b0, 8'd0,   fr(120, 119),1'b0, 1'b0, 1'b0, 32'h40000002, 1'b0, 1'b0);
      drive(1'b0, 8'd0,   fr(119, 0),  1'b0, 1'b0, 1'b0, 32'h40000001, 1'b0, 1'b0);
      drive(1'b0, 8'd0,   fr(119, -1), 1'b0, 1'b0, 1'b1, 32'h40000001, 1'b0, 1'b0);
      drive(1'b1, 8'd0,   fr(146, -1), 1'b0, 1'b0, 1'b0, 32'hBC000000, 1'b0, 1'b0);
      drive(1'b0, 8'hFF,  '0,          1'b0, 1'b0, 1'b0, 32'h38000000, 1'b0, 1'b0);
      drive(1'b0, 8'h88,  '0,          1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
      drive(1'b1, 8'h88,  '0,          1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
      drive(1'b0, 8'd119, '1,          1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
      drive(1'b0, 8'd5,   '0,          1'b0, 1'b0, 1'b0, 32'h64000000, 1'b0, 1'b0);
      idle(8);

      // Back-to-back burst with a downstream stall window
      @(negedge clk);
      #1;
      burst_start = cyc;
      stall_en    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 8'(i), '0, 1'b0, 1'b0, 1'b0, burst_exp[i], 1'b0, 1'b0);
      end
      idle(20);
      stall_en = 1'b0;

      // Reset with three beats in flight
      drive(1'b0, 8'd0, '0, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0);
      drive(1'b0, 8'd1, '0, 1'b0, 1'b0, 1'b0, 32'h48000000, 1'b0, 1'b0);
      drive(1'b0, 8'd2, '0, 1'b0, 1'b0, 1'b0, 32'h50000000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_outputs", 64'({out_result, out_inf, out_zero}), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("flush_release_in_ready", 64'(in_ready), 64'd1);
      idle(10);
      drive(1'b0, 8'd1, '0, 1'b0, 1'b0, 1'b0, 32'h48000000, 1'b0, 1'b0);
      idle(6);

      waitc = 0;
      while (exp_q.size() != 0 && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check("drain_queue", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/posit_normalize_accum_pipe.md
POSIT_NORMALIZE_ACCUM_PIPE -- requirements
Module: posit_normalize_accum_pipe

Interface
REQ-001 SHALL have parameter NBITS, default 32, posit output width (8..64).
REQ-002 SHALL have parameter ES, default 2, posit exponent field width (0..4).
REQ-003 SHALL have parameter FBITS, default 147, accumulator fraction width, hidden bit excluded, FBITS >= NBITS.
REQ-004 SHALL have parameter SCALE_W, default 8, two's-complement scale width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-009 SHALL have port in_sgn  input  1  sign.
REQ-010 SHALL have port in_scale  input  SCALE_W  signed scale, regime*2^ES + exponent.
REQ-011 SHALL have port in_fraction  input  FBITS  fraction, MSB-aligned, no hidden bit.
REQ-012 SHALL have port in_inf, in_zero, in_truncated  input  1 each  NaR flag, zero flag, sticky from upstream.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.
REQ-015 SHALL have port out_result  output  NBITS  encoded posit.
REQ-016 SHALL have port out_inf, out_zero  output  1 each  NaR / zero flags of out_result.

Function
REQ-017 SHALL be a 3-stage pipeline: S1 clamp scale, regime length, exponent, guard/sticky extraction; S2 regime insertion shift; S3 round, saturate, two's-complement, special-case mux.
REQ-018 SHALL transfer a beat when valid & ready on a port; latency 3 cycles with out_ready held high, throughput 1 beat/cycle.
REQ-019 SHALL use a global stall: stall = out_valid & ~out_ready; in_ready = ~stall; no stage advances while stall is high.
REQ-020 SHALL hold out_result/out_inf/out_zero stable while out_valid & ~out_ready.
REQ-021 SHALL preserve beat order, never drop or duplicate a beat.
REQ-022 SHALL clamp scale to [-(NBITS-2)*2^ES, (NBITS-2)*2^ES] before encoding.
REQ-023 SHALL round to nearest, ties to even: increment when guard & (lsb | sticky); sticky = in_truncated | OR of all discarded bits below guard.
REQ-024 SHALL never round a nonzero finite value to zero or NaR: magnitude saturates to maxpos (0x7F..F) or minpos (0x00..1).
REQ-025 SHALL negate the NBITS-1 magnitude (two's complement) when in_sgn=1, sign bit = in_sgn.
REQ-026 SHALL give in_inf priority: out_result = 1 followed by zeros, out_inf=1, out_zero=0.
REQ-027 SHALL, for in_zero & ~in_inf, output all zeros, out_zero=1.

Reset
REQ-028 SHALL, on reset assertion, immediately clear all stage valid bits, out_valid=0, out_result=0, out_inf=0, out_zero=0; in-flight beats are discarded.
REQ-029 SHALL assert in_ready=1 while reset is high and in the first cycle after release.

Structure
REQ-030 SHALL take NBITS/ES defaults, a value_accum-style packed struct (sgn, scale, fraction, inf, zero) and a maxpos/minpos function from the shared posit_defines package.
REQ-031 SHALL reuse the existing shift_right and shift_left barrel shifters; one sub-module, posit_round_sat (S3 rounding+saturation), is the natural split.

Verification
REQ-032 SHALL cover: sgn=0, scale=0, fraction=0 -> out_result 0x40000000 three cycles later (NBITS=32, ES=2).
REQ-033 SHALL cover: sgn=1, scale=0, fraction=0 -> 0xC0000000; scale=1 -> 0x48000000.
REQ-034 SHALL cover: scale=127 -> 0x7FFFFFFF; scale=-128, fraction nonzero -> 0x00000001.
REQ-035 SHALL cover: in_inf=1 -> 0x80000000, out_inf=1; in_zero=1 -> 0x00000000, out_zero=1.
REQ-036 SHALL cover: 6 back-to-back beats, out_ready low for cycles 4-8 -> in_ready low during stall, all 6 results in order, values unchanged while stalled.
REQ-037 SHALL cover: reset asserted with 3 beats in flight -> out_valid=0 the same cycle, no stale beat emerges after release.
